mem_wb_reg: RTL and testbench
=============================

// Module: mem_wb_reg
// PURPOSE
//   MEM/WB pipeline register of the 5-stage MIPS-style pipelined CPU.
//   Captures the MEM-stage control bits (regwrite, jump, memtoreg), the ALU result,
//   the data-memory read data and the destination register number, and presents
//   them to the WB stage one clock later.
//   Pure storage: no decoding, no arithmetic.
// PARAMETERS
//   DATA_W  32  width of the ALU-result and memory-read-data paths
//   REG_W    5  width of the destination register index
// PORTS (declaration order is fixed; the CPU top instantiates positionally)
//   startin        in   1       async reset, active-low; all outputs cleared while 0
//   clk            in   1       single clock; rising edge active
//   regwriteIn     in   1       MEM-stage register-file write enable
//   jumpIn         in   1       MEM-stage jump flag
//   memtoregIn     in   1       MEM-stage writeback select (1 = memory data, 0 = ALU)
//   aluResultIn    in   DATA_W  ALU result from EX/MEM
//   memReadDataIn  in   DATA_W  data-memory read data
//   regDstMuxIn    in   REG_W   destination register index after the RegDst mux
//   regwrite       out  1       registered regwriteIn
//   jump           out  1       registered jumpIn
//   memtoreg       out  1       registered memtoregIn
//   aluResult      out  DATA_W  registered aluResultIn
//   memReadData    out  DATA_W  registered memReadDataIn
//   regDstMux      out  REG_W   registered regDstMuxIn
// BEHAVIOUR
//   - Reset: startin==0 forces every output to 0 immediately, without waiting for clk.
//     Outputs then hold 0 for as long as startin stays low, clock edges notwithstanding.
//   - Reset release: the first rising clk edge with startin==1 loads the inputs.
//     Release coincident with a clk edge: that edge is ignored; capture starts next edge.
//   - Normal: on every rising clk edge, all six outputs load their inputs together.
//     Latency is 1 cycle. There is no enable, stall or flush.
//   - Between edges, outputs are stable; input changes do not propagate combinationally.
//   - Widths are passed straight through: no extension, truncation or arithmetic.
//   - Reset mid-operation clears all fields in the same instant.
//     A partially cleared bundle is never visible.
//   - All outputs are driven directly from flops; no output logic.
// STRUCTURE
//   - Shared cpu_pkg: DATA_W=32 and REG_W=5 constants.
//   - Shared cpu_pkg: a packed struct mem_wb_t {regwrite, jump, memtoreg, aluResult,
//     memReadData, regDstMux}, reused by the WB stage and the hazard/forwarding unit.
//   - One natural sub-module: pipe_reg #(W).
//     Generic W-bit D flop with async active-low clear.
//     Instantiated once over the concatenated bundle (1+1+1+DATA_W+DATA_W+REG_W = 72 bits).
// TESTING
//   1. startin=0 with nonzero inputs, clk toggling -> all outputs 0 on every edge.
//   2. startin=1; inputs jump=1, memtoreg=1, regwrite=0, aluResult=40, memReadData=40,
//      regDstMux=17 -> at the next rising edge the outputs show exactly those values;
//      before that edge they are still 0.
//   3. Change inputs mid-cycle to aluResult=0xDEADBEEF, regDstMux=31, regwrite=1
//      -> outputs unchanged until the next rising edge, then updated.
//   4. Outputs loaded, then pull startin low between edges -> all outputs 0 immediately.
//   5. Release startin exactly at a rising edge -> outputs stay 0 at that edge and load
//      on the following edge.
//   6. Back-to-back distinct inputs each cycle (e.g. aluResult 1,2,3,... and regDstMux
//      cycling 0..31) -> each output trails its input by exactly one cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the MEM/WB bundle type.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // MEM/WB bundle as seen by the WB stage and the hazard/forwarding unit.
  // Field order matches the flat concatenation stored by mem_wb_reg.
  typedef struct packed {
    logic              regwrite;
    logic              jump;
    logic              memtoreg;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] memReadData;
    logic [REG_W-1:0]  regDstMux;
  } mem_wb_t;

  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage : cpu_pkg

// File: rtl/pipe_reg.sv
// Generic W-bit D flop bank with asynchronous active-low clear.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Clear the whole bank at once on reset, otherwise capture every rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : pipe_reg

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: stores the MEM-stage control bits, ALU result,
// memory read data and destination register for use by WB one cycle later.
// Pure storage; all outputs come straight from flops.
import cpu_pkg::*;

module mem_wb_reg #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_W  = cpu_pkg::REG_W
) (
  input  logic              startin,
  input  logic              clk,
  input  logic              regwriteIn,
  input  logic              jumpIn,
  input  logic              memtoregIn,
  input  logic [DATA_W-1:0] aluResultIn,
  input  logic [DATA_W-1:0] memReadDataIn,
  input  logic [REG_W-1:0]  regDstMuxIn,
  output logic              regwrite,
  output logic              jump,
  output logic              memtoreg,
  output logic [DATA_W-1:0] aluResult,
  output logic [DATA_W-1:0] memReadData,
  output logic [REG_W-1:0]  regDstMux
);

  // One flat bundle so reset clears every field in the same instant.
  localparam int W_BUNDLE = 3 + 2 * DATA_W + REG_W;

  logic [W_BUNDLE-1:0] w_d;
  logic [W_BUNDLE-1:0] w_q;

  assign w_d = {regwriteIn, jumpIn, memtoregIn, aluResultIn, memReadDataIn, regDstMuxIn};

  pipe_reg #(
    .W (W_BUNDLE)
  ) u_pipe_reg (
    .i_clk   (clk),
    .i_rst_n (startin),
    .i_d     (w_d),
    .o_q     (w_q)
  );

  assign {regwrite, jump, memtoreg, aluResult, memReadData, regDstMux} = w_q;

endmodule : mem_wb_reg

// File: tb/tb_mem_wb_reg.sv
// Directed bench for mem_wb_reg: reset, capture, input stability,
// async clear, release timing and back-to-back streaming.
module tb_mem_wb_reg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int BW     = 3 + 2 * DATA_W + REG_W;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              startin;
  logic              regwriteIn;
  logic              jumpIn;
  logic              memtoregIn;
  logic [DATA_W-1:0] aluResultIn;
  logic [DATA_W-1:0] memReadDataIn;
  logic [REG_W-1:0]  regDstMuxIn;
  logic              regwrite;
  logic              jump;
  logic              memtoreg;
  logic [DATA_W-1:0] aluResult;
  logic [DATA_W-1:0] memReadData;
  logic [REG_W-1:0]  regDstMux;

  int checks   = 0;
  int failures = 0;

  logic [BW-1:0] obs;
  logic [BW-1:0] exp_v;
  logic [BW-1:0] zero_v;

  always #5 clk = ~clk;

  assign obs = {regwrite, jump, memtoreg, aluResult, memReadData, regDstMux};

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) dut (
    .startin       (startin),
    .clk           (clk),
    .regwriteIn    (regwriteIn),
    .jumpIn        (jumpIn),
    .memtoregIn    (memtoregIn),
    .aluResultIn   (aluResultIn),
    .memReadDataIn (memReadDataIn),
    .regDstMuxIn   (regDstMuxIn),
    .regwrite      (regwrite),
    .jump          (jump),
    .memtoreg      (memtoreg),
    .aluResult     (aluResult),
    .memReadData   (memReadData),
    .regDstMux     (regDstMux)
  );

  // ---------------- driver ----------------
  task automatic drive(input logic rw, input logic jp, input logic m2r,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                       input logic [REG_W-1:0] rd);
    regwriteIn    = rw;
    jumpIn        = jp;
    memtoregIn    = m2r;
    aluResultIn   = alu;
    memReadDataIn = mem;
    regDstMuxIn   = rd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    startin = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 5'd31);
    #1;
    checks++;
    if (obs !== zero_v) begin
      failures++;
      $display("FAIL reset_initial obs=%h exp=%h", obs, zero_v);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== zero_v) begin
        failures++;
        $display("FAIL reset_hold edge=%0d obs=%h exp=%h", i, obs, zero_v);
      end
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    startin = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 32'd40, 32'd40, 5'd17);
    #2;
    checks++;
    if (obs !== zero_v) begin
      failures++;
      $display("FAIL capture_before_edge obs=%h exp=%h", obs, zero_v);
    end
    exp_v = {1'b0, 1'b1, 1'b1, 32'd40, 32'd40, 5'd17};
    @(posedge clk); #1;
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL capture_after_edge obs=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_midcycle();
    logic [BW-1:0] prev;
    prev = {1'b0, 1'b1, 1'b1, 32'd40, 32'd40, 5'd17};
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'd40, 5'd31);
    #1;
    checks++;
    if (obs !== prev) begin
      failures++;
      $display("FAIL midcycle_stable_early obs=%h exp=%h", obs, prev);
    end
    #3;
    checks++;
    if (obs !== prev) begin
      failures++;
      $display("FAIL midcycle_stable_late obs=%h exp=%h", obs, prev);
    end
    exp_v = {1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'd40, 5'd31};
    @(posedge clk); #1;
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL midcycle_update obs=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1;
    startin = 1'b0;
    #1;
    checks++;
    if (obs !== zero_v) begin
      failures++;
      $display("FAIL async_clear obs=%h exp=%h", obs, zero_v);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== zero_v) begin
      failures++;
      $display("FAIL async_hold_edge obs=%h exp=%h", obs, zero_v);
    end
  endtask

  task automatic test_release();
    drive(1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 32'h0F0F_F0F0, 5'd9);
    @(posedge clk);
    #1;
    startin = 1'b1;
    #1;
    checks++;
    if (obs !== zero_v) begin
      failures++;
      $display("FAIL release_edge_ignored obs=%h exp=%h", obs, zero_v);
    end
    exp_v = {1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 32'h0F0F_F0F0, 5'd9};
    @(posedge clk); #1;
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL release_next_edge obs=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] cur;
    logic [BW-1:0] want;
    for (int i = 0; i < 40; i++) begin
      cur = {i[0], i[1], i[2], 32'(i + 1), ~32'(i), 5'(i % 32)};
      drive(cur[BW-1], cur[BW-2], cur[BW-3], 32'(i + 1), ~32'(i), 5'(i % 32));
      exp_q.push_back(cur);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL back_to_back cycle=%0d obs=%h exp=%h", i, obs, want);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    zero_v = '0;
    test_reset();
    test_capture();
    test_midcycle();
    test_async_reset();
    test_release();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout obs=%h exp=finished", obs);
    $fatal(1, "timeout");
  end

endmodule : tb_mem_wb_reg
